// File: rtl/formula_1_credit_buffer.sv
// Credit-based flow-control wrapper for formula_1_pipe: gates argument issue on
// reserved FIFO slots and buffers fixed-latency pipe results behind ready/valid.
module formula_1_credit_buffer #(
    parameter int DEPTH = 8,
    parameter int W     = 32,
    localparam int CW   = $clog2(DEPTH + 1),
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    // source side
    input  logic          in_vld,
    output logic          in_rdy,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [W-1:0]  in_c,
    // pipe argument side
    output logic          arg_vld,
    output logic [W-1:0]  a,
    output logic [W-1:0]  b,
    output logic [W-1:0]  c,
    // pipe result side
    input  logic          res_vld,
    input  logic [W-1:0]  res,
    // sink side
    output logic          out_vld,
    input  logic          out_rdy,
    output logic [W-1:0]  out_data,
    output logic [CW-1:0] count,
    output logic          err
);

    logic [CW-1:0] reserved_q, reserved_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic          err_q, err_d;
    logic [W-1:0]  mem_q [DEPTH];

    logic issue, pop, push, full, none_in_flight;

    // in_rdy depends on registered state only, so no comb path from in_vld/out_rdy.
    assign in_rdy  = (reserved_q < CW'(DEPTH));
    assign arg_vld = in_vld & in_rdy;
    assign a       = in_a;
    assign b       = in_b;
    assign c       = in_c;

    assign out_vld  = (count_q != '0);
    assign out_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign err      = err_q;

    assign issue          = arg_vld;
    assign pop            = out_vld & out_rdy;
    assign full           = (count_q == CW'(DEPTH));
    // A result arriving with nothing outstanding in the pipe cannot be ours.
    assign none_in_flight = (reserved_q == count_q);
    assign push           = res_vld & ~none_in_flight & (~full | pop);

    always_comb begin
        reserved_d = reserved_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        err_d      = err_q | (res_vld & ~push);

        case ({issue, pop})
            2'b10:   reserved_d = reserved_q + 1'b1;
            2'b01:   reserved_d = reserved_q - 1'b1;
            default: reserved_d = reserved_q;
        endcase

        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reserved_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            err_q      <= 1'b0;
        end else begin
            reserved_q <= reserved_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            err_q      <= err_d;
        end
    end

    // Storage is data-only; validity lives in count_q, so it is never reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= res;
    end

endmodule

// File: tb/tb_formula_1_credit_buffer.sv
// Bench for formula_1_credit_buffer: behavioural fixed-latency pipe plus a
// queue scoreboard whose monitor checks every popped result in order.
module tb_formula_1_credit_buffer;

    localparam int DEPTH = 8;
    localparam int W     = 32;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int LAT   = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_vld, in_rdy;
    logic [W-1:0]  in_a, in_b, in_c;
    logic          arg_vld;
    logic [W-1:0]  a, b, c;
    logic          res_vld;
    logic [W-1:0]  res;
    logic          out_vld, out_rdy;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
    logic          err;
    logic          stray;

    int tests = 0;
    int fails = 0;
    logic [W-1:0] exp_q [$];

    always #5 clk = ~clk;

    formula_1_credit_buffer #(.DEPTH(DEPTH), .W(W)) dut (
        .clk(clk), .rst(rst),
        .in_vld(in_vld), .in_rdy(in_rdy), .in_a(in_a), .in_b(in_b), .in_c(in_c),
        .arg_vld(arg_vld), .a(a), .b(b), .c(c),
        .res_vld(res_vld), .res(res),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_data(out_data),
        .count(count), .err(err)
    );

    // Stand-in pipe function; for (16,9,4) it gives 8+2+0 = 10.
    function automatic logic [W-1:0] f(input logic [W-1:0] x, y, z);
        return (x >> 1) + (y >> 2) + (z >> 3);
    endfunction

    logic [LAT-1:0] pv;
    logic [W-1:0]   pr [LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) pv <= '0;
        else begin
            pv    <= {pv[LAT-2:0], arg_vld};
            pr[0] <= f(a, b, c);
            for (int i = 1; i < LAT; i++) pr[i] <= pr[i-1];
        end
    end
    assign res_vld = pv[LAT-1] | stray;
    assign res     = pr[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push on accepted source transfer, pop/compare on sink transfer.
    always @(negedge clk) begin
        if (!rst) begin
            check("arg_vld", arg_vld, in_vld & in_rdy);
            if (arg_vld) check("arg_passthru", (a == in_a) && (b == in_b) && (c == in_c), 1);
            if (in_vld && in_rdy) exp_q.push_back(f(in_a, in_b, in_c));
            if (out_vld && out_rdy) begin
                if (exp_q.size() == 0) check("unexpected_out", 1, 0);
                else check("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; exp_q.delete();
        in_vld = 0; out_rdy = 0; stray = 0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_vld = 0; out_rdy = 1;
        while (exp_q.size() != 0 && n < 200) begin @(posedge clk); n++; end
        #1;
        check("drain_timeout", exp_q.size(), 0);
        check("drain_count", count, 0);
    endtask

    // Hold in_vld with out_rdy low for 20 cycles; returns number of transfers.
    task automatic fill(input int base, output int n);
        n = 0; out_rdy = 0; in_vld = 1;
        in_a = base; in_b = 0; in_c = 0;
        repeat (20) begin
            @(negedge clk);
            if (in_vld && in_rdy) n++;
            tick();
            in_a = base + n; in_b = 4 * n; in_c = 8 * n;
        end
        in_vld = 0;
    endtask

    initial begin
        int k, pulses, n;
        logic seen;
        rst = 1; in_vld = 0; out_rdy = 0; stray = 0;
        in_a = 0; in_b = 0; in_c = 0;
        repeat (2) @(posedge clk); #1;
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_vld", out_vld, 0);
        check("rst_count", count, 0);
        check("rst_err", err, 0);
        rst = 0; tick();

        // 1: single transaction latency and value
        out_rdy = 1; in_vld = 1; in_a = 16; in_b = 9; in_c = 4;
        k = 0; pulses = 0;
        while (k < 20) begin
            @(negedge clk);
            if (arg_vld) pulses++;
            if (out_vld) break;
            k++;
            tick(); in_vld = 0;
        end
        check("t1_latency", k, LAT + 1);
        check("t1_pulses", pulses, 1);
        check("t1_data", out_data, 10);
        tick(); drain();

        // 2: fill to credit limit, then drain in order
        fill(100, n);
        check("t2_transfers", n, 8);
        check("t2_in_rdy_low", in_rdy, 0);
        check("t2_count", count, 8);
        check("t2_err", err, 0);
        out_rdy = 1;
        @(negedge clk); check("t2_rdy_pop_cycle", in_rdy, 0);
        @(negedge clk); check("t2_rdy_after_pop", in_rdy, 1);
        tick(); drain();

        // 3: streaming
        out_rdy = 1; in_vld = 1;
        for (int i = 0; i < 100; i++) begin
            in_a = i * 37 + 5; in_b = i * 11 + 3; in_c = i * 101;
            @(negedge clk);
            check("t3_count_le1", count <= 1, 1);
            check("t3_in_rdy", in_rdy, 1);
            tick();
        end
        drain();

        // 4: pop one from full FIFO and issue one replacement
        fill(200, n);
        check("t4_count_full", count, 8);
        out_rdy = 1; in_vld = 1; in_a = 64; in_b = 64; in_c = 64;
        @(negedge clk);
        check("t4_A_count", count, 8);
        check("t4_A_in_rdy", in_rdy, 0);
        tick(); out_rdy = 0;
        @(negedge clk);
        check("t4_B_in_rdy", in_rdy, 1);
        check("t4_B_count", count, 7);
        tick(); in_vld = 0;
        @(negedge clk);
        check("t4_reserved_full", in_rdy, 0);
        repeat (LAT - 1) @(negedge clk);
        check("t4_before_arrival", count, 7);
        @(negedge clk);
        check("t4_after_arrival", count, 8);
        check("t4_err", err, 0);
        tick(); drain();

        // 5: stray pipe output sets sticky err
        do_reset();
        tick(); stray = 1; tick(); stray = 0;
        @(negedge clk);
        check("t5_err", err, 1);
        check("t5_count", count, 0);
        check("t5_out_vld", out_vld, 0);
        repeat (5) tick();
        check("t5_err_sticky", err, 1);

        // 6: reset with 3 stored and 2 in flight
        do_reset();
        check("t6_err_cleared", err, 0);
        out_rdy = 0; in_vld = 1; in_a = 7; in_b = 7; in_c = 7;
        repeat (5) tick();
        in_vld = 0;
        tick();
        check("t6_stored", count, 3);
        rst = 1; exp_q.delete(); #1;
        check("t6_out_vld", out_vld, 0);
        check("t6_count", count, 0);
        check("t6_in_rdy", in_rdy, 1);
        repeat (2) tick();
        rst = 0; out_rdy = 1; seen = 0;
        repeat (12) begin @(negedge clk); if (out_vld) seen = 1; end
        check("t6_no_stale", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
